// File: rtl/mdu_seq_if.sv
// mdu_seq_if: issue/complete handshake between the execute stage and the
// iterative RV32M multiply/divide unit. The pipeline side is the master.
interface mdu_seq_if #(
    parameter int XLEN = 32
);
    logic            start;
    logic            kill;
    logic [2:0]      op;
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] rs2;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;

    modport master (
        output start, kill, op, rs1, rs2,
        input  busy, done, result
    );

    modport slave (
        input  start, kill, op, rs1, rs2,
        output busy, done, result
    );
endinterface

// File: rtl/mdu_seq.sv
// mdu_seq: iterative RV32M multiply/divide unit.
// Multiplies use radix-2 shift-add and divides use radix-2 restoring division,
// both over 32 CALC cycles on operand magnitudes, with the sign applied in FIX.
// Divide-by-zero and signed-overflow divides skip CALC and complete in one cycle.
// Optional build macro MDU_FAST_MUL_EN: multiplies use one combinational
// 33x33 signed multiplier and complete in one cycle like the special cases.
module mdu_seq #(
    parameter int XLEN = 32
) (
    input logic       clk,
    input logic       rst,
    mdu_seq_if.slave  bus
);

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [2:0] OP_REMU   = 3'b111;

    localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [5:0]      LAST_CNT = 6'(XLEN-1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX
    } state_t;

    state_t state, state_next;

    // Latched operation context
    logic [2:0]        op_q;
    logic              neg_q;
    logic              direct_q;
    logic [XLEN-1:0]   direct_res_q;
    logic [5:0]        cnt;

    // Shared datapath: product / {unused, quotient} in acc, divisor or multiplicand in opnd
    logic [2*XLEN-1:0] acc;
    logic [XLEN-1:0]   opnd;
    logic [XLEN:0]     rem;

    logic [XLEN-1:0]   result_q;
    logic              done_q;

    // Issue-time decode
    logic              accept;
    logic              a_signed, b_signed;
    logic              a_neg, b_neg, res_neg;
    logic [XLEN-1:0]   a_mag, b_mag;
    logic              direct;
    logic [XLEN-1:0]   direct_res;

    // Iteration helpers
    logic [XLEN:0]     mul_sum;
    logic [XLEN+1:0]   div_shift;
    logic [XLEN+1:0]   div_diff;
    logic              div_ge;

    // Completion helpers
    logic [2*XLEN-1:0] mul_full;
    logic [XLEN-1:0]   mul_word, quo_word, rem_word, div_word, final_word;

    assign accept   = (state == IDLE) && bus.start && !bus.kill;

    // MULHSU treats only rs1 as signed; MULHU/DIVU/REMU are fully unsigned
    assign a_signed = (bus.op != OP_MULHU) && (bus.op != OP_DIVU) && (bus.op != OP_REMU);
    assign b_signed = (bus.op == OP_MUL) || (bus.op == OP_MULH) ||
                      (bus.op == OP_DIV) || (bus.op == OP_REM);
    assign a_neg    = a_signed & bus.rs1[XLEN-1];
    assign b_neg    = b_signed & bus.rs2[XLEN-1];
    assign a_mag    = a_neg ? -bus.rs1 : bus.rs1;
    assign b_mag    = b_neg ? -bus.rs2 : bus.rs2;
    // Remainder follows the dividend; quotient and product follow the XOR
    assign res_neg  = (bus.op == OP_REM) ? a_neg : (a_neg ^ b_neg);

`ifdef MDU_FAST_MUL_EN
    logic [2*XLEN-1:0] fast_a, fast_b, fast_prod;

    // Sign-extended operands; the low 2*XLEN bits equal the 33x33 signed product
    assign fast_a    = {{XLEN{a_signed & bus.rs1[XLEN-1]}}, bus.rs1};
    assign fast_b    = {{XLEN{b_signed & bus.rs2[XLEN-1]}}, bus.rs2};
    assign fast_prod = fast_a * fast_b;
`endif

    // Detect operations that finish without iterating and compute their result
    always_comb begin
        direct     = 1'b0;
        direct_res = '0;
        if (bus.op[2]) begin
            if (bus.rs2 == '0) begin
                direct     = 1'b1;
                direct_res = bus.op[1] ? bus.rs1 : '1;
            end else if (!bus.op[0] && (bus.rs1 == MIN_INT) && (bus.rs2 == '1)) begin
                direct     = 1'b1;
                direct_res = bus.op[1] ? '0 : MIN_INT;
            end
        end
`ifdef MDU_FAST_MUL_EN
        else begin
            direct     = 1'b1;
            direct_res = (bus.op == OP_MUL) ? fast_prod[XLEN-1:0] : fast_prod[2*XLEN-1:XLEN];
        end
`endif
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; kill always returns to IDLE and drops any start
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (accept) state_next = direct ? FIX : CALC;
            CALC: if (cnt == LAST_CNT) state_next = FIX;
            FIX:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (bus.kill) begin
            state_next = IDLE;
        end
    end

    // One shift-add step and one restoring-division step
    always_comb begin
        mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : '0);
        div_shift = {rem, acc[XLEN-1]};
        div_diff  = div_shift - {2'b00, opnd};
        div_ge    = ~div_diff[XLEN+1];
    end

    // Operand capture at issue and iteration during CALC
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q         <= '0;
            neg_q        <= 1'b0;
            direct_q     <= 1'b0;
            direct_res_q <= '0;
            cnt          <= '0;
            acc          <= '0;
            opnd         <= '0;
            rem          <= '0;
        end else if (accept) begin
            op_q         <= bus.op;
            neg_q        <= res_neg;
            direct_q     <= direct;
            direct_res_q <= direct_res;
            cnt          <= '0;
            rem          <= '0;
            if (bus.op[2]) begin
                acc  <= {{XLEN{1'b0}}, a_mag};
                opnd <= b_mag;
            end else begin
                acc  <= {{XLEN{1'b0}}, b_mag};
                opnd <= a_mag;
            end
        end else if (state == CALC) begin
            cnt <= cnt + 6'd1;
            if (op_q[2]) begin
                acc <= {acc[2*XLEN-1:XLEN], acc[XLEN-2:0], div_ge};
                rem <= div_ge ? div_diff[XLEN:0] : div_shift[XLEN:0];
            end else begin
                acc <= {mul_sum, acc[XLEN-1:1]};
            end
        end
    end

    // Sign correction and word selection for the final result
    always_comb begin
        mul_full   = neg_q ? -acc : acc;
        mul_word   = (op_q == OP_MUL) ? mul_full[XLEN-1:0] : mul_full[2*XLEN-1:XLEN];
        quo_word   = neg_q ? -acc[XLEN-1:0] : acc[XLEN-1:0];
        rem_word   = neg_q ? -rem[XLEN-1:0] : rem[XLEN-1:0];
        div_word   = op_q[1] ? rem_word : quo_word;
        final_word = mul_word;
        if (direct_q) begin
            final_word = direct_res_q;
        end else if (op_q[2]) begin
            final_word = div_word;
        end
    end

    // Register the result and pulse done on leaving FIX unless killed
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done_q   <= 1'b0;
            result_q <= '0;
        end else begin
            done_q <= 1'b0;
            if ((state == FIX) && !bus.kill) begin
                done_q   <= 1'b1;
                result_q <= final_word;
            end
        end
    end

    assign bus.busy   = (state != IDLE);
    assign bus.done   = done_q;
    assign bus.result = result_q;

endmodule
